// File: rtl/debug_pkg.sv
// Shared definitions for the debug register-dump streamer.
//
// Contents:
//   DUMP_HDR      - frame header byte
//   dump_state_t  - streamer state encoding
//   frame_len()   - number of bytes in one frame for a given register file
//
// Optional feature macro: DEBUG_DUMP_CSUM_EN (adds the XOR checksum trailer).
package debug_pkg;

    localparam logic [7:0] DUMP_HDR = 8'hA5;

`ifdef DEBUG_DUMP_CSUM_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } dump_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } dump_state_t;
`endif

    // Header byte + payload (+ checksum trailer when enabled).
    function automatic int frame_len(input int nregs, input int xlen);
`ifdef DEBUG_DUMP_CSUM_EN
        return 2 + nregs * xlen / 8;
`else
        return 1 + nregs * xlen / 8;
`endif
    endfunction

endpackage

// File: rtl/debug_reg_dump.sv
// Debug register-dump streamer.
//
// On dump_req, snapshots the whole register file and streams it as a framed
// byte sequence: 8'hA5, then regs 0..NREGS-1 little-endian, then (optionally)
// an XOR checksum of the payload bytes.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst_n      - asynchronous active-low reset
//   regs_in    - flattened register file, reg i at [i*XLEN +: XLEN]
//   dump_req   - dump request, sampled each rising edge
//   out_data   - stream byte (registered)
//   out_valid  - out_data valid (registered)
//   out_ready  - consumer ready; handshake = out_valid && out_ready
//   busy       - a frame is in progress
//   overrun    - sticky: request dropped because one was already pending
//
// Optional feature macro: DEBUG_DUMP_CSUM_EN (checksum trailer state).
module debug_reg_dump
    import debug_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREGS*XLEN-1:0]  regs_in,
    input  logic                   dump_req,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   overrun
);

    localparam int NBYTES = XLEN / 8;
    localparam int RW     = $clog2(NREGS);
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [RW-1:0] LAST_REG  = RW'(NREGS - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);

    dump_state_t           state, state_n;
    logic [RW-1:0]         reg_idx, reg_idx_n;
    logic [BW-1:0]         byte_idx, byte_idx_n;
    logic                  pending, pending_n;
    logic                  overrun_q, overrun_n;
    logic                  active_q;
    logic [7:0]            data_q, data_n;
    logic                  snap_en;
    logic                  frame_done;
    logic                  hs;
    logic [NREGS*XLEN-1:0] snapshot;
`ifdef DEBUG_DUMP_CSUM_EN
    logic [7:0]            csum, csum_n;
`endif

    assign hs        = active_q && out_ready;
    assign out_valid = active_q;
    assign busy      = active_q;
    assign out_data  = data_q;
    assign overrun   = overrun_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_n    = state;
        reg_idx_n  = reg_idx;
        byte_idx_n = byte_idx;
        pending_n  = pending;
        overrun_n  = overrun_q;
        snap_en    = 1'b0;
        frame_done = 1'b0;
`ifdef DEBUG_DUMP_CSUM_EN
        csum_n     = csum;
`endif

        case (state)
            ST_HDR: begin
                if (hs) begin
                    state_n    = ST_DATA;
                    reg_idx_n  = '0;
                    byte_idx_n = '0;
`ifdef DEBUG_DUMP_CSUM_EN
                    csum_n     = 8'h00;
`endif
                end
            end
            ST_DATA: begin
                if (hs) begin
`ifdef DEBUG_DUMP_CSUM_EN
                    csum_n = csum ^ data_q;
`endif
                    if (byte_idx == LAST_BYTE) begin
                        byte_idx_n = '0;
                        if (reg_idx == LAST_REG) begin
`ifdef DEBUG_DUMP_CSUM_EN
                            state_n    = ST_CSUM;
`else
                            state_n    = ST_IDLE;
                            frame_done = 1'b1;
`endif
                        end else begin
                            reg_idx_n = reg_idx + RW'(1);
                        end
                    end else begin
                        byte_idx_n = byte_idx + BW'(1);
                    end
                end
            end
`ifdef DEBUG_DUMP_CSUM_EN
            ST_CSUM: begin
                if (hs) begin
                    state_n    = ST_IDLE;
                    frame_done = 1'b1;
                end
            end
`endif
            default: ;
        endcase

        // Request arbitration. A frame completing this edge behaves like IDLE,
        // so a queued or simultaneous request starts the next frame with no gap.
        if (state == ST_IDLE || frame_done) begin
            if (pending) begin
                snap_en   = 1'b1;
                state_n   = ST_HDR;
                pending_n = dump_req;
            end else if (dump_req) begin
                snap_en = 1'b1;
                state_n = ST_HDR;
            end
        end else if (dump_req) begin
            if (pending) overrun_n = 1'b1;
            else         pending_n = 1'b1;
        end

        // Output byte for the next cycle; computed from next-state values so
        // out_data is a flop with no path from out_ready within a cycle.
        case (state_n)
            ST_HDR:  data_n = DUMP_HDR;
            ST_DATA: data_n = snapshot[int'(reg_idx_n)*XLEN + int'(byte_idx_n)*8 +: 8];
`ifdef DEBUG_DUMP_CSUM_EN
            ST_CSUM: data_n = csum_n;
`endif
            default: data_n = 8'h00;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            reg_idx   <= '0;
            byte_idx  <= '0;
            pending   <= 1'b0;
            overrun_q <= 1'b0;
            active_q  <= 1'b0;
            data_q    <= 8'h00;
`ifdef DEBUG_DUMP_CSUM_EN
            csum      <= 8'h00;
`endif
        end else begin
            state     <= state_n;
            reg_idx   <= reg_idx_n;
            byte_idx  <= byte_idx_n;
            pending   <= pending_n;
            overrun_q <= overrun_n;
            active_q  <= (state_n != ST_IDLE);
            data_q    <= data_n;
`ifdef DEBUG_DUMP_CSUM_EN
            csum      <= csum_n;
`endif
        end
    end

    // NOTE: the snapshot buffer is deliberately not reset; it is always
    // written before it is read, and a reset on it would only cost flops.
    always_ff @(posedge clk) begin
        if (snap_en) snapshot <= regs_in;
    end

endmodule

// File: tb/tb_debug_reg_dump.sv
// Self-checking bench for debug_reg_dump.
// A byte-queue model builds each expected frame from regs_in when the frame
// starts; a compare process checks every cycle against it, and directed
// literal checks pin the model. Define DEBUG_DUMP_CSUM_EN for the checksum build.
module tb_debug_reg_dump;
    import debug_pkg::*;

    localparam int NREGS = 32;
    localparam int XLEN  = 32;
`ifdef DEBUG_DUMP_CSUM_EN
    localparam int FLEN = 130;
`else
    localparam int FLEN = 129;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREGS*XLEN-1:0] regs_in = '0;
    logic                  dump_req = 1'b0;
    logic                  out_ready = 1'b1;
    logic [7:0]            out_data;
    logic                  out_valid;
    logic                  busy;
    logic                  overrun;

    debug_reg_dump #(.NREGS(NREGS), .XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .regs_in   (regs_in),
        .dump_req  (dump_req),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] exp_q[$];
    bit         mpend = 1'b0;
    bit         movr  = 1'b0;

    task automatic push_frame();
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < NREGS; i++) begin
            for (int k = 0; k < XLEN/8; k++) begin
                b = regs_in[i*XLEN + k*8 +: 8];
                x = x ^ b;
                exp_q.push_back(b);
            end
        end
`ifdef DEBUG_DUMP_CSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    initial begin : model
        bit active;
        bit done;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                mpend = 1'b0;
                movr  = 1'b0;
            end else begin
                active = (exp_q.size() != 0);
                done   = 1'b0;
                if (active && out_ready) begin
                    void'(exp_q.pop_front());
                    done = (exp_q.size() == 0);
                end
                if (!active || done) begin
                    if (mpend) begin
                        push_frame();
                        mpend = dump_req;
                    end else if (dump_req) begin
                        push_frame();
                    end
                end else if (dump_req) begin
                    if (mpend) movr = 1'b1;
                    else       mpend = 1'b1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [7:0] cap[$];
    int         busy_cycles = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    initial begin : compare
        bit exp_valid;
        forever begin
            @(negedge clk);
            exp_valid = (exp_q.size() != 0);
            check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
            check("busy", {31'd0, busy}, {31'd0, exp_valid});
            check("overrun", {31'd0, overrun}, {31'd0, movr});
            if (exp_valid) check("out_data", {24'd0, out_data}, {24'd0, exp_q[0]});
            if (prev_stall && rst_n) begin
                check("stall_valid_held", {31'd0, out_valid}, 32'd1);
                check("stall_data_held", {24'd0, out_data}, {24'd0, prev_data});
            end
            prev_stall = rst_n && out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && out_ready) cap.push_back(out_data);
            if (busy) busy_cycles++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req();
        dump_req = 1'b1;
        step();
        dump_req = 1'b0;
    endtask

    task automatic set_pattern();
        for (int i = 0; i < NREGS; i++) regs_in[i*XLEN +: XLEN] = 32'h1000_0000 + i;
    endtask

    task automatic wait_idle(input int max_cycles, input bit stall);
        int g;
        g = 0;
        while ((busy || exp_q.size() != 0) && g < max_cycles) begin
            if (stall) out_ready = 1'($urandom_range(0, 1));
            step();
            g++;
        end
        out_ready = 1'b1;
        check("wait_idle_in_budget", {31'd0, (g < max_cycles)}, 32'd1);
    endtask

    initial begin : stim
        int n_at_rst;
        int g;

        // Reset state
        set_pattern();
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);

        // Basic frame, out_ready high
        cap.delete();
        busy_cycles = 0;
        pulse_req();
        check("hdr_latency_valid", {31'd0, out_valid}, 32'd1);
        check("hdr_latency_data", {24'd0, out_data}, 32'hA5);
        wait_idle(400, 1'b0);
        check("frame_len", cap.size(), FLEN);
        check("frame_busy_cycles", busy_cycles, FLEN);
        check("byte0_hdr", {24'd0, cap[0]}, 32'hA5);
        check("byte1", {24'd0, cap[1]}, 32'h00);
        check("byte4", {24'd0, cap[4]}, 32'h10);
        check("byte5", {24'd0, cap[5]}, 32'h01);
        check("byte125_reg31_lsb", {24'd0, cap[125]}, 32'h1F);
        check("byte128_reg31_msb", {24'd0, cap[128]}, 32'h10);
`ifdef DEBUG_DUMP_CSUM_EN
        check("csum_trailer_pattern", {24'd0, cap[129]}, 32'h00);
`endif

        // Random 50% stalls
        cap.delete();
        pulse_req();
        wait_idle(2000, 1'b1);
        check("stalled_len", cap.size(), FLEN);
        check("stalled_byte5", {24'd0, cap[5]}, 32'h01);
        check("stalled_byte128", {24'd0, cap[128]}, 32'h10);

        // Snapshot frozen against regs_in changes
        cap.delete();
        pulse_req();
        regs_in = '1;
        wait_idle(400, 1'b0);
        check("snap_byte1", {24'd0, cap[1]}, 32'h00);
        check("snap_byte125", {24'd0, cap[125]}, 32'h1F);
        set_pattern();

        // Back-to-back: one pending request, a third one overruns
        cap.delete();
        busy_cycles = 0;
        pulse_req();
        repeat (10) step();
        pulse_req();
        check("pending_no_overrun", {31'd0, overrun}, 32'd0);
        repeat (10) step();
        pulse_req();
        check("overrun_set", {31'd0, overrun}, 32'd1);
        wait_idle(800, 1'b0);
        check("b2b_len", cap.size(), 2 * FLEN);
        check("b2b_no_gap", busy_cycles, 2 * FLEN);
        check("b2b_second_hdr", {24'd0, cap[FLEN]}, 32'hA5);
        check("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Reset mid-frame at byte 40
        cap.delete();
        pulse_req();
        g = 0;
        while (cap.size() < 40 && g < 200) begin
            step();
            g++;
        end
        check("reach_byte40", {31'd0, (cap.size() >= 40)}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_overrun", {31'd0, overrun}, 32'd0);
        n_at_rst = cap.size();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (20) step();
        check("no_resume_after_rst", cap.size(), n_at_rst);
        check("idle_after_rst", {31'd0, busy}, 32'd0);

`ifdef DEBUG_DUMP_CSUM_EN
        // Checksum: reg1 = 0xFF, others 0
        regs_in = '0;
        regs_in[1*XLEN +: XLEN] = 32'h0000_00FF;
        cap.delete();
        pulse_req();
        wait_idle(400, 1'b0);
        check("csum_ff_len", cap.size(), FLEN);
        check("csum_ff_trailer", {24'd0, cap[FLEN-1]}, 32'hFF);
`endif

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
